// File: rtl/pattern_scan_pkg.sv
// -----------------------------------------------------------------------------
// pattern_scan_pkg
// Shared definitions for the pattern scan controller and its 10110 detector:
// controller and detector state encodings, the searched pattern, and the
// default word / counter widths.
// -----------------------------------------------------------------------------
package pattern_scan_pkg;

   localparam int DEF_W  = 16;
   localparam int DEF_CW = 5;

   // Pattern recognised by the detector, oldest bit in the MSB.
   localparam logic [4:0] PATTERN = 5'b10110;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_REPORT = 2'd2
   } ctrl_state_e;

   // Detector states name the longest suffix of the input that is a prefix
   // of the pattern: none, 1, 10, 101, 1011.
   typedef enum logic [2:0] {
      DET_D0 = 3'd0,
      DET_D1 = 3'd1,
      DET_D2 = 3'd2,
      DET_D3 = 3'd3,
      DET_D4 = 3'd4
   } det_state_e;

endpackage

// File: rtl/seq_det_10110.sv
// -----------------------------------------------------------------------------
// seq_det_10110
// Overlapping Mealy detector for the serial pattern 10110.
// Ports:
//   clk    - clock, rising edge
//   rst    - asynchronous active-low reset (state -> D0)
//   en     - consume bit_in this cycle
//   clr    - return to D0 on the next edge (wins over en)
//   bit_in - serial input bit
//   match  - combinational: high when en and bit_in completes the pattern
// -----------------------------------------------------------------------------
module seq_det_10110
   import pattern_scan_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   input  logic bit_in,
   output logic match
);

   det_state_e state_q, state_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DET_D0;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = DET_D0;
      end else if (en) begin
         case (state_q)
            DET_D0:  state_d = bit_in ? DET_D1 : DET_D0;
            DET_D1:  state_d = bit_in ? DET_D1 : DET_D2;
            DET_D2:  state_d = bit_in ? DET_D3 : DET_D0;
            DET_D3:  state_d = bit_in ? DET_D4 : DET_D2;
            // After a completion, the trailing "10" is reused for overlap.
            DET_D4:  state_d = bit_in ? DET_D1 : DET_D2;
            default: state_d = DET_D0;
         endcase
      end
   end

   // Completion is seeing the pattern's last bit while holding "1011".
   assign match = en && (state_q == DET_D4) && (bit_in == PATTERN[0]);

endmodule

// File: rtl/pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_scan_ctrl
// Accepts a W-bit word, shifts it MSB first through the 10110 detector (one
// bit per cycle), counts pattern completions and records the bit index of the
// first one, then holds the result until the consumer takes it.
// Ports:
//   clk, rst              - clock; asynchronous active-low reset
//   in_valid / in_ready   - word handshake (in_word, in_cont)
//   in_word               - word to scan
//   in_cont               - 1 keeps detector state from the previous word
//   abort                 - synchronous cancel; also clears the detector
//   out_valid / out_ready - result handshake
//   match_cnt             - saturating completion count
//   first_pos             - bit index (0 = MSB) completing the first match
//   any_match             - match_cnt != 0
//   busy                  - scanning or holding a result
// -----------------------------------------------------------------------------
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
#(
   parameter int W  = DEF_W,
   parameter int CW = DEF_CW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W-1:0]         in_word,
   input  logic                 in_cont,
   input  logic                 abort,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CW-1:0]        match_cnt,
   output logic [$clog2(W)-1:0] first_pos,
   output logic                 any_match,
   output logic                 busy
);

   localparam int IW = $clog2(W);
   localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   ctrl_state_e   state_q, state_d;
   logic [W-1:0]  word_q, word_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] first_q, first_d;
   logic          in_ready_q, in_ready_d;

   logic det_en;
   logic det_clr;
   logic det_match;

   seq_det_10110 u_det (
      .clk    (clk),
      .rst    (rst),
      .en     (det_en),
      .clr    (det_clr),
      .bit_in (word_q[W-1]),
      .match  (det_match)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         word_q     <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         first_q    <= '0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         in_ready_q <= in_ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      det_en  = 1'b0;
      det_clr = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (abort) begin
               det_clr = 1'b1;
            end else if (in_valid && in_ready_q) begin
               word_d  = in_word;
               idx_d   = '0;
               cnt_d   = '0;
               first_d = '0;
               // Clear lands on the accept edge, before the first bit.
               det_clr = !in_cont;
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (abort) begin
               det_clr = 1'b1;
               idx_d   = '0;
               cnt_d   = '0;
               first_d = '0;
               state_d = ST_IDLE;
            end else begin
               det_en = 1'b1;
               // The word register shifts so its MSB is always bit idx.
               word_d = {word_q[W-2:0], 1'b0};
               if (det_match) begin
                  // Count never returns to zero once set, so zero marks
                  // "no match yet" even after saturation.
                  if (cnt_q == '0) begin
                     first_d = idx_q;
                  end
                  if (cnt_q != CNT_MAX) begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = ST_REPORT;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         ST_REPORT: begin
            if (abort) begin
               det_clr = 1'b1;
               cnt_d   = '0;
               first_d = '0;
               state_d = ST_IDLE;
            end else if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered so in_ready stays low throughout reset and rises on the
   // first edge after release.
   assign in_ready_d = (state_d == ST_IDLE);

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q == ST_REPORT);
   assign busy      = (state_q != ST_IDLE);
   assign match_cnt = cnt_q;
   assign first_pos = first_q;
   assign any_match = (cnt_q != '0);

endmodule
